repetition_range_checker: RTL and testbench

REPETITION_RANGE_CHECKER -- requirements
Module: repetition_range_checker

---
 rtl/rep_chk_pkg.sv | 18 +
 rtl/rep_chk_chan.sv | 97 +++++++++
 rtl/repetition_range_checker.sv | 101 ++++++++++
 tb/tb_repetition_range_checker.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rep_chk_pkg.sv
// Shared types for the repetition range checker: per-channel state and verdict encodings.
package rep_chk_pkg;

    typedef enum logic {
        CHK_IDLE,
        CHK_RUN
    } chk_state_e;

    typedef enum logic [1:0] {
        V_NONE,
        V_PASS,
        V_FAIL
    } verdict_e;

    localparam int unsigned MaxChannels = 32;
    localparam int unsigned MaxRepLimit = 255;

endpackage

// File: rtl/rep_chk_chan.sv
// One checker channel: a trigger rise starts a check that counts consecutive req samples
// and issues a registered pass/fail verdict, or an overlap pulse for an ignored trigger.
module rep_chk_chan
    import rep_chk_pkg::*;
#(
    parameter int unsigned MIN_REP = 2,
    parameter int unsigned MAX_REP = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     strict,
    input  logic     trig,
    input  logic     req,
    output verdict_e verdict,
    output logic     pass,
    output logic     fail,
    output logic     ovl,
    output logic     busy
);

    localparam int unsigned CW = $clog2(MAX_REP + 2);
    localparam logic [CW-1:0] MinCnt = CW'(MIN_REP);
    localparam logic [CW-1:0] MaxCnt = CW'(MAX_REP);

    chk_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          trig_q;
    logic          rise;
    logic          ovl_d;
    logic          pass_q, fail_q, ovl_q;

    always_comb begin
        rise    = trig & ~trig_q;
        cnt_inc = cnt_q + CW'(1);
        state_d = state_q;
        cnt_d   = cnt_q;
        verdict = V_NONE;
        ovl_d   = 1'b0;
        unique case (state_q)
            CHK_IDLE: begin
                if (rise) begin
                    state_d = CHK_RUN;
                    cnt_d   = '0;
                end
            end
            CHK_RUN: begin
                // >= rather than == so a strict->relaxed switch mid-run still terminates
                if (req) begin
                    if (!strict && (cnt_inc >= MinCnt)) begin
                        verdict = V_PASS;
                    end else if (strict && (cnt_q >= MaxCnt)) begin
                        verdict = V_FAIL;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else if (cnt_q < MinCnt) begin
                    verdict = V_FAIL;
                end else begin
                    verdict = V_PASS;
                end

                if (verdict != V_NONE) begin
                    // A rise on the deciding edge re-arms the channel without an overlap
                    state_d = rise ? CHK_RUN : CHK_IDLE;
                    cnt_d   = '0;
                end else begin
                    ovl_d = rise;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CHK_IDLE;
            cnt_q   <= '0;
            trig_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            ovl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trig_q  <= trig;
            pass_q  <= (verdict == V_PASS);
            fail_q  <= (verdict == V_FAIL);
            ovl_q   <= ovl_d;
        end
    end

    assign pass = pass_q;
    assign fail = fail_q;
    assign ovl  = ovl_q;
    assign busy = (state_q == CHK_RUN);

endmodule

// File: rtl/repetition_range_checker.sv
// Multi-channel repetition range checker: NCH independent channels plus saturating
// aggregate pass/fail totals that count verdicts on the edge they are decided.
module repetition_range_checker
    import rep_chk_pkg::*;
#(
    parameter int unsigned NCH     = 4,
    parameter int unsigned MIN_REP = 2,
    parameter int unsigned MAX_REP = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             strict_i,
    input  logic             clr_i,
    input  logic [NCH-1:0]   trig_i,
    input  logic [NCH-1:0]   req_i,
    output logic [NCH-1:0]   pass_o,
    output logic [NCH-1:0]   fail_o,
    output logic [NCH-1:0]   ovl_o,
    output logic [NCH-1:0]   busy_o,
    output logic [CNT_W-1:0] pass_total_o,
    output logic [CNT_W-1:0] fail_total_o
);

    localparam int unsigned PW = $clog2(NCH + 1);
    localparam int unsigned SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
    localparam logic [CNT_W-1:0] CntMax = '1;

    if (NCH < 1 || NCH > MaxChannels) begin : g_err_nch
        $error("NCH must be within 1..32");
    end
    if (MIN_REP < 1) begin : g_err_min
        $error("MIN_REP must be at least 1");
    end
    if (MAX_REP < MIN_REP) begin : g_err_order
        $error("MAX_REP must not be below MIN_REP");
    end
    if (MAX_REP > MaxRepLimit) begin : g_err_max
        $error("MAX_REP must not exceed 255");
    end

    verdict_e         verdict [NCH];
    logic [PW-1:0]    pass_cnt, fail_cnt;
    logic [CNT_W-1:0] pass_total_q, pass_total_d;
    logic [CNT_W-1:0] fail_total_q, fail_total_d;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        rep_chk_chan #(
            .MIN_REP (MIN_REP),
            .MAX_REP (MAX_REP)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .strict  (strict_i),
            .trig    (trig_i[i]),
            .req     (req_i[i]),
            .verdict (verdict[i]),
            .pass    (pass_o[i]),
            .fail    (fail_o[i]),
            .ovl     (ovl_o[i]),
            .busy    (busy_o[i])
        );
    end

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [PW-1:0]    b);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b);
        return (s > SW'(CntMax)) ? CntMax : s[CNT_W-1:0];
    endfunction

    always_comb begin
        pass_cnt = '0;
        fail_cnt = '0;
        for (int i = 0; i < NCH; i++) begin
            pass_cnt = pass_cnt + PW'(verdict[i] == V_PASS);
            fail_cnt = fail_cnt + PW'(verdict[i] == V_FAIL);
        end
        if (clr_i) begin
            pass_total_d = '0;
            fail_total_d = '0;
        end else begin
            pass_total_d = sat_add(pass_total_q, pass_cnt);
            fail_total_d = sat_add(fail_total_q, fail_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_total_q <= '0;
            fail_total_q <= '0;
        end else begin
            pass_total_q <= pass_total_d;
            fail_total_q <= fail_total_d;
        end
    end

    assign pass_total_o = pass_total_q;
    assign fail_total_o = fail_total_q;

endmodule

// File: tb/tb_repetition_range_checker.sv
// Scoreboard bench: a run-count reference model queues expected outputs per edge,
// a negedge monitor compares them against two instances (wide and 2-bit totals).
module tb_repetition_range_checker;

    localparam int NCH     = 4;
    localparam int MIN_REP = 2;
    localparam int MAX_REP = 4;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       strict = 1'b0;
    logic       clr    = 1'b0;
    logic [3:0] trig   = '0;
    logic [3:0] req    = '0;

    logic [3:0]  pass_o, fail_o, ovl_o, busy_o;
    logic [15:0] pt_o, ft_o;
    logic [3:0]  pass2, fail2, ovl2, busy2;
    logic [1:0]  pt2_o, ft2_o;

    repetition_range_checker #(
        .NCH(NCH), .MIN_REP(MIN_REP), .MAX_REP(MAX_REP), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .strict_i(strict), .clr_i(clr),
        .trig_i(trig), .req_i(req), .pass_o(pass_o), .fail_o(fail_o),
        .ovl_o(ovl_o), .busy_o(busy_o), .pass_total_o(pt_o), .fail_total_o(ft_o)
    );

    repetition_range_checker #(
        .NCH(NCH), .MIN_REP(MIN_REP), .MAX_REP(MAX_REP), .CNT_W(2)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .strict_i(strict), .clr_i(clr),
        .trig_i(trig), .req_i(req), .pass_o(pass2), .fail_o(fail2),
        .ovl_o(ovl2), .busy_o(busy2), .pass_total_o(pt2_o), .fail_total_o(ft2_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] pass, fail, ovl, busy;
        int         pt, ft, pt2, ft2;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    bit m_active[4] = '{default: 1'b0};
    bit m_prev[4]   = '{default: 1'b0};
    int m_nhigh[4]  = '{default: 0};
    int m_pt = 0, m_ft = 0, m_pt2 = 0, m_ft2 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Reference model: a check is a count of consecutive high samples judged against the window
    always @(posedge clk) begin : model
        exp_t e;
        bit   rise, p, f, o;
        int   np, nf;
        e.pass = '0; e.fail = '0; e.ovl = '0; e.busy = '0;
        np = 0; nf = 0;
        if (rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                rise = trig[c] && !m_prev[c];
                m_prev[c] = trig[c];
                p = 0; f = 0; o = 0;
                if (m_active[c]) begin
                    if (req[c]) begin
                        m_nhigh[c]++;
                        if (!strict && m_nhigh[c] >= MIN_REP) p = 1;
                        else if (strict && m_nhigh[c] > MAX_REP) f = 1;
                    end else if (m_nhigh[c] < MIN_REP) begin
                        f = 1;
                    end else begin
                        p = 1;
                    end
                    if (p || f) begin
                        m_active[c] = rise;
                        m_nhigh[c]  = 0;
                    end else if (rise) begin
                        o = 1;
                    end
                end else if (rise) begin
                    m_active[c] = 1;
                    m_nhigh[c]  = 0;
                end
                e.pass[c] = p; e.fail[c] = f; e.ovl[c] = o; e.busy[c] = m_active[c];
                np += int'(p); nf += int'(f);
            end
            m_pt  = clr ? 0 : sat(m_pt + np, 65535);
            m_ft  = clr ? 0 : sat(m_ft + nf, 65535);
            m_pt2 = clr ? 0 : sat(m_pt2 + np, 3);
            m_ft2 = clr ? 0 : sat(m_ft2 + nf, 3);
        end
        e.pt = m_pt; e.ft = m_ft; e.pt2 = m_pt2; e.ft2 = m_ft2;
        sbq.push_back(e);
    end

    always @(negedge rst_n) begin
        for (int c = 0; c < NCH; c++) begin
            m_active[c] = 0; m_prev[c] = 0; m_nhigh[c] = 0;
        end
        m_pt = 0; m_ft = 0; m_pt2 = 0; m_ft2 = 0;
        sbq.delete();
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("pass_o", 32'(pass_o), 32'(e.pass));
            chk("fail_o", 32'(fail_o), 32'(e.fail));
            chk("ovl_o", 32'(ovl_o), 32'(e.ovl));
            chk("busy_o", 32'(busy_o), 32'(e.busy));
            chk("pass_total", 32'(pt_o), e.pt);
            chk("fail_total", 32'(ft_o), e.ft);
            chk("pass_total_sat", 32'(pt2_o), e.pt2);
            chk("fail_total_sat", 32'(ft2_o), e.ft2);
        end
    end

    task automatic cyc(input logic [3:0] t, input logic [3:0] r);
        trig = t;
        req  = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] t, r;
        #12;
        chk("reset_busy", 32'(busy_o), 0);
        chk("reset_pass", 32'(pass_o | fail_o | ovl_o), 0);
        chk("reset_totals", 32'(pt_o) + 32'(ft_o), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Relaxed: two highs pass, high then low fails
        cyc(4'h1, 4'h0); cyc(4'h1, 4'h1); cyc(4'h1, 4'h1);
        chk("relaxed_pass", 32'(pass_o[0]), 1);
        chk("relaxed_pass_total", 32'(pt_o), 1);
        cyc(4'h0, 4'h0);
        cyc(4'h1, 4'h0); cyc(4'h1, 4'h1); cyc(4'h1, 4'h0);
        chk("short_fail", 32'(fail_o[0]), 1);
        chk("short_fail_total", 32'(ft_o), 1);
        cyc(4'h0, 4'h0);

        // Strict: five highs fail, three highs then low pass
        strict = 1'b1;
        cyc(4'h1, 4'h0);
        repeat (5) cyc(4'h1, 4'h1);
        chk("strict_over_fail", 32'(fail_o[0]), 1);
        cyc(4'h0, 4'h0);
        cyc(4'h1, 4'h0);
        repeat (3) cyc(4'h1, 4'h1);
        cyc(4'h1, 4'h0);
        chk("strict_window_pass", 32'(pass_o[0]), 1);
        cyc(4'h0, 4'h0);

        // Overlap on ch1, then a rise exactly on the deciding edge
        cyc(4'h2, 4'h0); cyc(4'h0, 4'h2); cyc(4'h2, 4'h2); cyc(4'h0, 4'h0);
        cyc(4'h0, 4'h0);
        cyc(4'h2, 4'h0); cyc(4'h0, 4'h2); cyc(4'h0, 4'h2); cyc(4'h2, 4'h0);
        chk("rearm_busy", 32'(busy_o[1]), 1);
        chk("rearm_no_ovl", 32'(ovl_o[1]), 0);
        cyc(4'h2, 4'h2); cyc(4'h2, 4'h2); cyc(4'h0, 4'h0);
        strict = 1'b0;

        // Simultaneous passes, saturation of narrow totals, clear priority
        cyc(4'h5, 4'h0); cyc(4'h5, 4'h5); cyc(4'h5, 4'h5); cyc(4'h0, 4'h0);
        cyc(4'hF, 4'h0); cyc(4'hF, 4'hF); cyc(4'hF, 4'hF);
        chk("narrow_saturate", 32'(pt2_o), 3);
        cyc(4'h0, 4'h0);
        cyc(4'hF, 4'h0); cyc(4'hF, 4'hF);
        clr = 1'b1;
        cyc(4'hF, 4'hF);
        clr = 1'b0;
        chk("clr_priority", 32'(pt_o), 0);
        cyc(4'h0, 4'h0);

        // Reset mid-run, trigger held through release
        cyc(4'h1, 4'h0);
        cyc(4'h1, 4'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_busy", 32'(busy_o), 0);
        chk("async_reset_totals", 32'(pt_o) + 32'(ft_o), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("held_trig_rise", 32'(busy_o[0]), 1);
        cyc(4'h1, 4'h0); cyc(4'h0, 4'h0);

        for (int k = 0; k < 3000; k++) begin
            for (int b = 0; b < NCH; b++) begin
                t[b] = ($urandom_range(0, 5) == 0) ? ~trig[b] : trig[b];
            end
            r = 4'($urandom);
            if ($urandom_range(0, 49) == 0) strict = ~strict;
            clr = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 599) == 0) begin
                #2 rst_n = 1'b0;
                @(posedge clk);
                #3 rst_n = 1'b1;
                @(posedge clk);
                #1;
            end
            cyc(t, r);
        end
        clr = 1'b0;
        repeat (8) cyc(4'h0, 4'h0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
